// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, widths, command-master FSM
// states and the operation legality check. Imported by the ALU and by
// alu_cmd_master so the select encodings cannot diverge.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_DIV = 4'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } cm_state_t;

    // Only the four encoded operations are legal; 4..15 are rejected.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_cmd_master.sv
// Command-side initiator for the 8-bit registered ALU. Accepts one command
// at a time over a valid/ready channel, drives the ALU operand/select
// inputs, captures the registered result and returns it with an error flag
// and the caller's tag over a valid/ready response channel.
module alu_cmd_master
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag
);

    cm_state_t state;
    cm_state_t state_nxt;
    logic      cmd_err;
    logic      cmd_fire;

    // Illegal select, or a divide whose divisor is zero, never reaches the ALU.
    always_comb begin
        cmd_err = !is_legal_op(cmd_op) || ((cmd_op == ALU_DIV) && (cmd_b == '0));
    end

    // State register; reset returns to IDLE from any state, dropping work in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; cmd_ready is gated by rst so it reads 0 while reset is held.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = rst;
                if (cmd_valid && rst) begin
                    state_nxt = cmd_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        cmd_fire = cmd_valid && cmd_ready;
    end

    // Datapath: the alu_* registers double as the command latch for legal
    // commands; the tag is latched straight into rsp_tag, which only changes
    // on an accept and so stays stable throughout RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            if (cmd_fire) begin
                rsp_tag <= cmd_tag;
                if (cmd_err) begin
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                end else begin
                    alu_a   <= cmd_a;
                    alu_b   <= cmd_b;
                    alu_sel <= cmd_op;
                end
            end
            if (state == ST_WAIT) begin
                rsp_result <= alu_result;
                rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_cmd_master.md
# alu_cmd_master

Command-side initiator for the 8-bit registered ALU. It accepts operation requests over a valid/ready command channel and drives the ALU operand and select inputs. It captures the ALU's registered result and returns it with status over a valid/ready response channel. It sits between the test/control logic and the ALU, and is the only block that drives the ALU inputs.

## Interface
Parameters:
- TAG_W, 4, width of the command tag echoed on the response

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV; all other values illegal
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_tag  in  TAG_W  caller tag
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_sel  out  4  ALU operation select
- alu_result  in  8  ALU registered result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  8  result, truncated to 8 bits
- rsp_err  out  1  1 = illegal op or divide by zero
- rsp_tag  out  TAG_W  tag of the originating command

## Operation
- Handshakes:
  - A command transfers on the cycle cmd_valid && cmd_ready.
  - A response transfers on the cycle rsp_valid && rsp_ready.
  - rsp_valid and all rsp_* fields are held stable until the response transfers.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On a command transfer, latch op, a, b and tag.
  - Legal op with no error: load alu_a/alu_b/alu_sel from the command at the same edge, then go to ISSUE.
  - Illegal op (4..15), or DIV with b==0: do not change alu_*. Set rsp_result=8'h00 and rsp_err=1, then go to RESP.
- ISSUE: alu_* are stable; the ALU samples them at the end of this cycle. Go to WAIT.
- WAIT: at the end of the cycle, capture alu_result into rsp_result, set rsp_err=0, then go to RESP.
- RESP:
  - rsp_valid=1, cmd_ready=0.
  - On rsp_ready, go to IDLE.
- alu_a/alu_b/alu_sel hold their last issued values between commands and are never driven with an illegal select.
- Arithmetic is performed entirely by the ALU. This block does not check or modify the result beyond the error substitution above. ADD, SUB and MUL wrap modulo 256; DIV is an unsigned quotient.
- Reset (rst==0 at a rising edge), from any state, including mid-ISSUE/WAIT/RESP:
  - state goes to IDLE.
  - Outputs: cmd_ready=0 during reset, rsp_valid=0, rsp_result=0, rsp_err=0, rsp_tag=0, alu_a=0, alu_b=0, alu_sel=0.
  - Any in-flight command is dropped with no response.
  - cmd_ready rises to 1 in the first cycle after reset is released.

## Timing
- Legal command accepted at edge N (end of cycle N):
  - alu_* are valid from cycle N+1 (ISSUE).
  - The ALU updates at the end of N+1.
  - rsp_valid=1 from cycle N+3.
- Error command accepted at edge N: rsp_valid=1 from cycle N+1.
- Throughput with rsp_ready held high:
  - Legal commands: one command per 4 cycles.
  - Error commands: one command per 2 cycles.
- Backpressure: each cycle with rsp_ready=0 in RESP adds one cycle. cmd_ready stays 0 until the response transfers.
- A cmd_valid asserted while cmd_ready=0 must be held by the source. No command is lost or duplicated.
- The ALU's own reset is driven separately. This block assumes the ALU is out of reset whenever rst==1.

## Structure
- Shared package alu_pkg:
  - op enum ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_DIV=3.
  - OP_W=4, DATA_W=8.
  - FSM state typedef.
  - Legality function is_legal_op(op).
- The ALU and this block both import alu_pkg so the select encodings cannot diverge.
- Single flat module with no sub-module. The command latch, FSM and response register are all local.

## Test plan
- ADD a=7, b=5, tag=3 -> alu_sel=0 in ISSUE; rsp_valid 3 cycles after accept; rsp_result=0x0C, rsp_err=0, rsp_tag=3.
- SUB 20-30, MUL 16*17, DIV 100/7, each issued back-to-back with rsp_ready=1 -> results 0xF6, 0x10, 0x0E; accepts spaced exactly 4 cycles apart.
- op=5, a=1, b=1 -> rsp_valid 1 cycle after accept, rsp_result=0x00, rsp_err=1; alu_sel never shows 5 and alu_* are unchanged.
- DIV a=9, b=0 -> rsp_err=1, rsp_result=0x00; alu_* are unchanged.
- ADD 1+1 with rsp_ready=0 for 5 cycles -> rsp_* stay stable with rsp_result=0x02; cmd_ready stays 0; a second cmd_valid is held and accepted in the cycle after the response transfers.
- rst=0 asserted during WAIT of MUL 3*3 -> no response issued; all outputs are 0 on the following cycle; after release, ADD 2+2 returns 0x04.
